imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 12 +
 rtl/imem_loader.sv | 106 ++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
// Holds the FSM encoding and the stream framing widths.
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_FIN   = 3'd5
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready handshake between a byte source and the loader.
// The source is the master and the loader is the slave.
interface imem_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into RAM as 32-bit words.
// Words go to consecutive addresses from 0; abort returns to idle immediately.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    imem_loader_if.slave      byte_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [COUNT_W:0] DEPTH = {{COUNT_W{1'b0}}, 1'b1} << ADDR_W;

    state_e               state_q, state_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [ADDR_W-1:0]    addr_q,  addr_d;
    logic [DATA_W-1:0]    word_q,  word_d;
    logic [1:0]           idx_q,   idx_d;
    logic                 err_q,   err_d;
    logic                 accept;
    logic [COUNT_W:0]     len_full;

    // abort wins over a same-cycle byte, so it masks ready combinationally
    assign byte_in.in_ready = ((state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                               (state_q == ST_DATA)) && !abort;
    assign accept    = byte_in.in_valid && byte_in.in_ready;
    assign mem_we    = (state_q == ST_WRITE) && !abort;
    assign done      = (state_q == ST_FIN) && !abort;
    assign busy      = (state_q != ST_IDLE);
    assign err       = err_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign len_full  = {1'b0, byte_in.in_data, count_q[7:0]};

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        word_d  = word_q;
        idx_d   = idx_q;
        err_d   = err_q;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    state_d = ST_LEN0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    addr_d  = '0;
                end
                ST_LEN0: if (accept) begin
                    count_d[7:0] = byte_in.in_data;
                    state_d      = ST_LEN1;
                end
                ST_LEN1: if (accept) begin
                    count_d[15:8] = byte_in.in_data;
                    state_d       = (len_full == '0) ? ST_FIN : ST_DATA;
                    if (len_full > DEPTH) err_d = 1'b1;
                end
                ST_DATA: if (accept) begin
                    // shift right so the first byte ends up in the low lane
                    word_d = {byte_in.in_data, word_q[DATA_W-1:8]};
                    idx_d  = idx_q + 2'd1;
                    if (idx_q == 2'(BYTES_PER_WORD - 1)) state_d = ST_WRITE;
                end
                ST_WRITE: begin
                    addr_d  = addr_q + 1'b1;
                    count_d = count_q - COUNT_W'(1);
                    state_d = (count_q == COUNT_W'(1)) ? ST_FIN : ST_DATA;
                end
                ST_FIN:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 4096-word instance plus a 4-word instance
// for address wrap and the oversize-count error flag.
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       sel;
    logic       start_s;
    logic       abort_s;
    logic       src_valid;
    logic [7:0] src_data;

    imem_loader_if ifa();
    imem_loader_if ifb();

    logic [11:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we, a_busy, a_done, a_err;
    logic [1:0]  b_addr;
    logic [31:0] b_wdata;
    logic        b_we, b_busy, b_done, b_err;

    assign ifa.in_valid = src_valid & ~sel;
    assign ifa.in_data  = src_data;
    assign ifb.in_valid = src_valid & sel;
    assign ifb.in_data  = src_data;

    imem_loader #(.ADDR_W(12), .DATA_W(32)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_s & ~sel), .abort(abort_s & ~sel),
        .byte_in(ifa), .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we),
        .busy(a_busy), .done(a_done), .err(a_err));

    imem_loader #(.ADDR_W(2), .DATA_W(32)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_s & sel), .abort(abort_s & sel),
        .byte_in(ifb), .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
        .busy(b_busy), .done(b_done), .err(b_err));

    logic        m_rdy, m_we, m_busy, m_done, m_err;
    logic [11:0] m_addr;
    logic [31:0] m_wdata;
    assign m_rdy   = sel ? ifb.in_ready : ifa.in_ready;
    assign m_we    = sel ? b_we   : a_we;
    assign m_busy  = sel ? b_busy : a_busy;
    assign m_done  = sel ? b_done : a_done;
    assign m_err   = sel ? b_err  : a_err;
    assign m_addr  = sel ? {10'd0, b_addr} : a_addr;
    assign m_wdata = sel ? b_wdata : a_wdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM-side observer: records every write as the RAM would capture it
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] wq_addr[$];
    logic [31:0] wq_data[$];
    int          wq_cyc[$];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (m_we) begin
            wq_addr.push_back(32'(m_addr));
            wq_data.push_back(m_wdata);
            wq_cyc.push_back(cyc);
        end
        if (m_done) done_cnt <= done_cnt + 1;
    end

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
    endtask

    // Present a byte and hold it until the loader takes it; returns on the
    // falling edge after the accepting rising edge, with in_valid still high.
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        src_valid = 1'b1;
        src_data  = b;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            ok = m_rdy;
            @(negedge clk);
        end
        chk("byte_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int i = 0; i < 4; i++) begin
            if (gap) begin
                src_valid = 1'b0;
                @(negedge clk);
            end
            send(w[8*i +: 8]);
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            #1;
            if (m_done) seen = 1'b1;
            else @(negedge clk);
        end
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic chk_wr(input int idx, input logic [31:0] addr, input logic [31:0] data);
        chk("wr_addr", wq_addr[idx], addr);
        chk("wr_data", wq_data[idx], data);
    endtask

    initial begin
        int base;
        int dbase;
        rst_n = 1'b0; sel = 1'b0; start_s = 1'b0; abort_s = 1'b0;
        src_valid = 1'b0; src_data = 8'h00;
        repeat (2) @(negedge clk);
        // reset state
        chk("rst_in_ready", 32'(ifa.in_ready), 32'd0);
        chk("rst_mem_we",   32'(a_we),    32'd0);
        chk("rst_mem_addr", 32'(a_addr),  32'd0);
        chk("rst_wdata",    a_wdata,      32'd0);
        chk("rst_busy",     32'(a_busy),  32'd0);
        chk("rst_done",     32'(a_done),  32'd0);
        chk("rst_err",      32'(a_err),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // two-word image, valid held high
        base = wq_addr.size(); dbase = done_cnt;
        pulse_start();
        #1;
        chk("start_busy",  32'(m_busy), 32'd1);
        chk("start_ready", 32'(m_rdy),  32'd1);
        send(8'h02); send(8'h00);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        src_valid = 1'b0;
        wait_done();
        chk("fin_busy", 32'(m_busy), 32'd1);
        chk("fin_ready", 32'(m_rdy), 32'd0);
        @(negedge clk); #1;
        chk("idle_busy", 32'(m_busy), 32'd0);
        chk("idle_done", 32'(m_done), 32'd0);
        chk("img1_nwr", 32'(wq_addr.size() - base), 32'd2);
        chk_wr(base,     32'd0, 32'h12345678);
        chk_wr(base + 1, 32'd1, 32'hDEADBEEF);
        chk("img1_spacing", 32'(wq_cyc[base + 1] - wq_cyc[base]), 32'd5);
        chk("img1_done_cnt", 32'(done_cnt - dbase), 32'd1);
        chk("img1_err", 32'(m_err), 32'd0);

        // zero-length image
        base = wq_addr.size(); dbase = done_cnt;
        pulse_start();
        send(8'h00); send(8'h00);
        src_valid = 1'b0;
        #1;
        chk("len0_done", 32'(m_done), 32'd1);
        @(negedge clk); #1;
        chk("len0_done_gone", 32'(m_done), 32'd0);
        chk("len0_busy", 32'(m_busy), 32'd0);
        chk("len0_nwr", 32'(wq_addr.size() - base), 32'd0);
        chk("len0_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // same image with a bubble before every byte
        base = wq_addr.size(); dbase = done_cnt;
        pulse_start();
        send(8'h02); src_valid = 1'b0; @(negedge clk); send(8'h00);
        send_word(32'h12345678, 1'b1);
        send_word(32'hDEADBEEF, 1'b1);
        src_valid = 1'b0;
        wait_done();
        @(negedge clk);
        chk("gap_nwr", 32'(wq_addr.size() - base), 32'd2);
        chk_wr(base,     32'd0, 32'h12345678);
        chk_wr(base + 1, 32'd1, 32'hDEADBEEF);
        chk("gap_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // abort with the second byte of word 1 on the bus
        base = wq_addr.size(); dbase = done_cnt;
        pulse_start();
        send(8'h03); send(8'h00);
        send_word(32'h44332211, 1'b0);
        send(8'hAA);
        src_data = 8'hBB;
        abort_s  = 1'b1;
        #1;
        chk("abort_ready", 32'(m_rdy), 32'd0);
        chk("abort_busy_same", 32'(m_busy), 32'd1);
        @(negedge clk);
        abort_s = 1'b0; src_valid = 1'b0;
        #1;
        chk("abort_busy_next", 32'(m_busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("abort_nwr", 32'(wq_addr.size() - base), 32'd1);
        chk_wr(base, 32'd0, 32'h44332211);
        chk("abort_no_done", 32'(done_cnt - dbase), 32'd0);

        // 4-word RAM, count 5: wraps and flags err
        sel = 1'b1;
        @(negedge clk);
        base = wq_addr.size();
        pulse_start();
        send(8'h05); send(8'h00);
        #1;
        chk("wrap_err_set", 32'(m_err), 32'd1);
        for (int i = 0; i < 5; i++) send_word({24'h302010, 8'(i + 1)}, 1'b0);
        src_valid = 1'b0;
        wait_done();
        chk("wrap_err_held", 32'(m_err), 32'd1);
        @(negedge clk);
        chk("wrap_nwr", 32'(wq_addr.size() - base), 32'd5);
        chk_wr(base,     32'd0, 32'h30201001);
        chk_wr(base + 1, 32'd1, 32'h30201002);
        chk_wr(base + 2, 32'd2, 32'h30201003);
        chk_wr(base + 3, 32'd3, 32'h30201004);
        chk_wr(base + 4, 32'd0, 32'h30201005);
        chk("wrap_err_idle", 32'(m_err), 32'd1);
        pulse_start();
        #1;
        chk("wrap_err_clear", 32'(m_err), 32'd0);
        send(8'h00); send(8'h00);
        src_valid = 1'b0;
        wait_done();
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);

        // asynchronous reset after six data bytes, then a fresh load
        pulse_start();
        send(8'h02); send(8'h00);
        send_word(32'h01020304, 1'b0);
        send(8'h55); send(8'h66);
        src_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  32'(a_busy), 32'd0);
        chk("arst_ready", 32'(ifa.in_ready), 32'd0);
        chk("arst_we",    32'(a_we), 32'd0);
        chk("arst_addr",  32'(a_addr), 32'd0);
        chk("arst_wdata", a_wdata, 32'd0);
        chk("arst_done",  32'(a_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = wq_addr.size();
        pulse_start();
        send(8'h01); send(8'h00);
        send_word(32'hCAFEF00D, 1'b0);
        src_valid = 1'b0;
        wait_done();
        @(negedge clk);
        chk("reload_nwr", 32'(wq_addr.size() - base), 32'd1);
        chk_wr(base, 32'd0, 32'hCAFEF00D);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
